// File: rtl/simplerisc_pkg.sv
// SimpleRisc shared definitions: widths, op-class one-hot indices
// and the memory-access stage state type.
package simplerisc_pkg;

    localparam int MA_DATA_W = 32;
    localparam int MA_REG_W  = 4;

    // Op-class one-hot layout shared with the execute stage
    localparam int OP_W   = 16;
    localparam int OP_CMP = 5;
    localparam int OP_LD  = 13;
    localparam int OP_ST  = 14;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } ma_state_t;

    // Build the execute-side one-hot; LD wins when both LD and ST are set
    function automatic logic [OP_W-1:0] op_onehot(
        input logic is_ld,
        input logic is_st,
        input logic is_cmp
    );
        logic [OP_W-1:0] oh;
        oh         = '0;
        oh[OP_LD]  = is_ld;
        oh[OP_ST]  = is_st && !is_ld;
        oh[OP_CMP] = is_cmp;
        return oh;
    endfunction

endpackage

// File: rtl/ma_stage_if.sv
// Memory-access stage bundle: execute handshake, data-memory port,
// write-back handshake and flags. slave = stage, master = environment.
interface ma_stage_if
    import simplerisc_pkg::*;
#(
    parameter int DATA_W = MA_DATA_W,
    parameter int REG_W  = MA_REG_W
);

    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_store_data;
    logic              ex_is_ld;
    logic              ex_is_st;
    logic              ex_is_cmp;
    logic              ex_wb_en;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_gt;
    logic              ex_eq;

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;

    logic              rw_valid;
    logic              rw_ready;
    logic [DATA_W-1:0] rw_result;
    logic [REG_W-1:0]  rw_rd;
    logic              rw_wb_en;

    logic              flag_gt;
    logic              flag_eq;

    modport slave (
        input  ex_valid, ex_alu_result, ex_store_data,
        input  ex_is_ld, ex_is_st, ex_is_cmp,
        input  ex_wb_en, ex_rd, ex_gt, ex_eq,
        output ex_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output rw_valid, rw_result, rw_rd, rw_wb_en,
        input  rw_ready,
        output flag_gt, flag_eq
    );

    modport master (
        output ex_valid, ex_alu_result, ex_store_data,
        output ex_is_ld, ex_is_st, ex_is_cmp,
        output ex_wb_en, ex_rd, ex_gt, ex_eq,
        input  ex_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  rw_valid, rw_result, rw_rd, rw_wb_en,
        output rw_ready,
        input  flag_gt, flag_eq
    );

endinterface

// File: rtl/flag_reg.sv
// Architectural gt/eq flag register with load enable.
// Ports: clk, rst_n (sync, active low), load, gt_in/eq_in, gt/eq.
module flag_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic gt_in,
    input  logic eq_in,
    output logic gt,
    output logic eq
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gt <= 1'b0;
            eq <= 1'b0;
        end else if (load) begin
            gt <= gt_in;
            eq <= eq_in;
        end
    end

endmodule

// File: rtl/ma_stage.sv
// SimpleRisc memory-access stage: LD/ST on the data port, one buffered
// result to write-back, CMP flags. Ports: clk, rst_n, bus (ma_stage_if.slave).
module ma_stage
    import simplerisc_pkg::*;
#(
    parameter int DATA_W = MA_DATA_W,
    parameter int REG_W  = MA_REG_W
) (
    input  logic        clk,
    input  logic        rst_n,
    ma_stage_if.slave   bus
);

    ma_state_t state;
    ma_state_t state_nx;

    logic xfer;
    logic is_mem;

    logic              ld_q;
    logic              st_q;
    logic              wb_q;
    logic              rw_wb_en_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] result_q;
    logic [REG_W-1:0]  rd_q;

    // No path from ex_valid into ex_ready
    assign bus.ex_ready = (state == IDLE) ||
                          (state == HOLD && bus.rw_ready);
    assign xfer   = bus.ex_valid && bus.ex_ready;
    assign is_mem = bus.ex_is_ld || bus.ex_is_st;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (xfer) state_nx = is_mem ? REQ : HOLD;
            end
            REQ: begin
                // rvalid in the gnt cycle is deliberately not looked at
                if (bus.dmem_gnt) state_nx = ld_q ? WAIT : HOLD;
            end
            WAIT: begin
                if (bus.dmem_rvalid) state_nx = HOLD;
            end
            HOLD: begin
                if (xfer)             state_nx = is_mem ? REQ : HOLD;
                else if (bus.rw_ready) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            wb_q       <= 1'b0;
            rw_wb_en_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            result_q   <= '0;
            rd_q       <= '0;
        end else begin
            state <= state_nx;
            if (xfer) begin
                addr_q     <= bus.ex_alu_result;
                wdata_q    <= bus.ex_store_data;
                // LD+ST together is illegal; it behaves as a load
                ld_q       <= bus.ex_is_ld;
                st_q       <= bus.ex_is_st && !bus.ex_is_ld;
                wb_q       <= bus.ex_wb_en;
                rd_q       <= bus.ex_rd;
                result_q   <= bus.ex_alu_result;
                // Memory ops only expose wb_en once load data lands
                rw_wb_en_q <= is_mem ? 1'b0 : bus.ex_wb_en;
            end else if (state == WAIT && bus.dmem_rvalid) begin
                result_q   <= bus.dmem_rdata;
                rw_wb_en_q <= wb_q;
            end
        end
    end

    assign bus.dmem_req   = (state == REQ);
    assign bus.dmem_we    = st_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;

    assign bus.rw_valid  = (state == HOLD);
    assign bus.rw_result = result_q;
    assign bus.rw_rd     = rd_q;
    assign bus.rw_wb_en  = rw_wb_en_q;

    flag_reg u_flags (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (xfer && bus.ex_is_cmp),
        .gt_in (bus.ex_gt),
        .eq_in (bus.ex_eq),
        .gt    (bus.flag_gt),
        .eq    (bus.flag_eq)
    );

endmodule

// File: tb/tb_ma_stage.sv
// Bench for ma_stage: directed scenarios then random traffic, all
// checked against an instruction-level model of the stage.
module tb_ma_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ma_stage_if #(.DATA_W(32), .REG_W(4)) bus ();

    ma_stage #(.DATA_W(32), .REG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Instruction-level model: at most one instruction in flight
    logic        m_init    = 1'b0;
    logic        m_busy    = 1'b0;
    logic        m_avail   = 1'b0;
    logic        m_granted = 1'b0;
    logic        m_ld      = 1'b0;
    logic        m_st      = 1'b0;
    logic        m_wb      = 1'b0;
    logic        m_gt      = 1'b0;
    logic        m_eq      = 1'b0;
    logic [31:0] m_addr    = '0;
    logic [31:0] m_wdata   = '0;
    logic [31:0] m_res     = '0;
    logic [3:0]  m_rd      = '0;
    int          rv_delay  = 0;
    logic        last_acc  = 1'b0;

    task automatic chkb(input string tag, input logic o, input logic e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] o,
                        input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic idle_in();
        bus.ex_valid      = 1'b0;
        bus.ex_alu_result = '0;
        bus.ex_store_data = '0;
        bus.ex_is_ld      = 1'b0;
        bus.ex_is_st      = 1'b0;
        bus.ex_is_cmp     = 1'b0;
        bus.ex_wb_en      = 1'b0;
        bus.ex_rd         = '0;
        bus.ex_gt         = 1'b0;
        bus.ex_eq         = 1'b0;
        bus.dmem_gnt      = 1'b0;
        bus.dmem_rvalid   = 1'b0;
        bus.dmem_rdata    = '0;
        bus.rw_ready      = 1'b1;
    endtask

    task automatic set_ex(input logic [31:0] alu, input logic [31:0] sd,
                          input logic ld, input logic st, input logic cmp,
                          input logic wb, input logic [3:0] rd,
                          input logic gt, input logic eq);
        bus.ex_valid      = 1'b1;
        bus.ex_alu_result = alu;
        bus.ex_store_data = sd;
        bus.ex_is_ld      = ld;
        bus.ex_is_st      = st;
        bus.ex_is_cmp     = cmp;
        bus.ex_wb_en      = wb;
        bus.ex_rd         = rd;
        bus.ex_gt         = gt;
        bus.ex_eq         = eq;
    endtask

    // Inputs were set at the negedge; check, take the edge, advance model
    task automatic step();
        logic e_ready, e_req, e_rwv, acc, retire;
        logic s_rst, s_val, s_gnt, s_rv, s_rwr;
        logic s_ld, s_st, s_cmp, s_wb, s_gt, s_eq;
        logic [31:0] s_alu, s_sd, s_rdata;
        logic [3:0] s_rd;
        #1;
        e_ready = !m_busy || (m_avail && bus.rw_ready);
        e_req   = m_busy && (m_ld || m_st) && !m_granted;
        e_rwv   = m_busy && m_avail;
        if (m_init) begin
            chkb("ex_ready", bus.ex_ready, e_ready);
            chkb("dmem_req", bus.dmem_req, e_req);
            chkb("rw_valid", bus.rw_valid, e_rwv);
            chkb("flag_gt", bus.flag_gt, m_gt);
            chkb("flag_eq", bus.flag_eq, m_eq);
            if (e_req) begin
                chkw("dmem_addr", bus.dmem_addr, m_addr);
                chkb("dmem_we", bus.dmem_we, m_st);
                chkw("dmem_wdata", bus.dmem_wdata, m_wdata);
            end
            if (e_rwv) begin
                chkw("rw_result", bus.rw_result, m_res);
                chkw("rw_rd", 32'(bus.rw_rd), 32'(m_rd));
                chkb("rw_wb_en", bus.rw_wb_en, m_wb);
            end
        end
        s_rst = rst_n;          s_val = bus.ex_valid;
        s_gnt = bus.dmem_gnt;   s_rv = bus.dmem_rvalid;
        s_rwr = bus.rw_ready;   s_rdata = bus.dmem_rdata;
        s_ld = bus.ex_is_ld;    s_st = bus.ex_is_st;
        s_cmp = bus.ex_is_cmp;  s_wb = bus.ex_wb_en;
        s_gt = bus.ex_gt;       s_eq = bus.ex_eq;
        s_alu = bus.ex_alu_result; s_sd = bus.ex_store_data;
        s_rd = bus.ex_rd;
        @(posedge clk);
        last_acc = 1'b0;
        if (!s_rst) begin
            m_init = 1'b1; m_busy = 1'b0; m_avail = 1'b0;
            m_granted = 1'b0; m_gt = 1'b0; m_eq = 1'b0;
        end else begin
            retire = m_busy && m_avail && s_rwr;
            acc    = s_val && e_ready;
            if (e_req && s_gnt) begin
                m_granted = 1'b1;
                if (m_st) m_avail = 1'b1;
                else rv_delay = int'($urandom_range(0, 2));
            end else if (m_busy && m_ld && m_granted && !m_avail && s_rv) begin
                m_avail = 1'b1;
                m_res   = s_rdata;
            end
            if (acc) begin
                m_busy    = 1'b1;
                m_ld      = s_ld;
                m_st      = s_st && !s_ld;
                m_granted = 1'b0;
                m_avail   = !(s_ld || s_st);
                m_addr    = s_alu;
                m_wdata   = s_sd;
                m_res     = s_alu;
                m_rd      = s_rd;
                m_wb      = m_st ? 1'b0 : s_wb;
                if (s_cmp) begin
                    m_gt = s_gt;
                    m_eq = s_eq;
                end
                last_acc = 1'b1;
            end else if (retire) begin
                m_busy = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic mem_drive();
        bus.dmem_gnt = (m_busy && (m_ld || m_st) && !m_granted) ?
                       1'($urandom % 2) : 1'b0;
        if (m_busy && m_ld && m_granted && !m_avail) begin
            if (rv_delay == 0) begin
                bus.dmem_rvalid = 1'b1;
                bus.dmem_rdata  = $urandom;
            end else begin
                bus.dmem_rvalid = 1'b0;
                rv_delay--;
            end
        end else begin
            // Stray rvalid outside a load wait must be ignored
            bus.dmem_rvalid = (($urandom % 6) == 0);
            bus.dmem_rdata  = $urandom;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chkb({tag, "_req"}, bus.dmem_req, 1'b0);
        chkb({tag, "_we"}, bus.dmem_we, 1'b0);
        chkw({tag, "_addr"}, bus.dmem_addr, 32'h0);
        chkw({tag, "_wdata"}, bus.dmem_wdata, 32'h0);
        chkb({tag, "_rwv"}, bus.rw_valid, 1'b0);
        chkb({tag, "_wben"}, bus.rw_wb_en, 1'b0);
        chkw({tag, "_res"}, bus.rw_result, 32'h0);
        chkw({tag, "_rd"}, 32'(bus.rw_rd), 32'h0);
        chkb({tag, "_gt"}, bus.flag_gt, 1'b0);
        chkb({tag, "_eq"}, bus.flag_eq, 1'b0);
    endtask

    initial begin
        int k;
        idle_in();
        rst_n = 1'b0;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        check_reset_outputs("rst");
        step();
        chkb("rst_ex_ready", bus.ex_ready, 1'b1);

        // Non-memory ops back to back
        set_ex(32'h7, 32'h0, 0, 0, 0, 1, 4'd3, 0, 0);
        step();
        set_ex(32'hFFFF_FFFF, 32'h0, 0, 0, 0, 1, 4'd4, 0, 0);
        chkb("b2b_v0", bus.rw_valid, 1'b1);
        chkw("b2b_r0", bus.rw_result, 32'h7);
        step();
        idle_in();
        chkw("b2b_r1", bus.rw_result, 32'hFFFF_FFFF);
        chkw("b2b_rd1", 32'(bus.rw_rd), 32'd4);
        step();
        step();

        // Load with gnt and rvalid stalls
        set_ex(32'h100, 32'h0, 1, 0, 0, 1, 4'd5, 0, 0);
        step();
        idle_in();
        step();
        step();
        chkw("ld_addr_hold", bus.dmem_addr, 32'h100);
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        step();
        step();
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hDEAD_BEEF;
        step();
        idle_in();
        chkw("ld_res", bus.rw_result, 32'hDEAD_BEEF);
        chkb("ld_wben", bus.rw_wb_en, 1'b1);
        chkw("ld_rd", 32'(bus.rw_rd), 32'd5);
        step();

        // Store then write-back backpressure
        set_ex(32'h40, 32'h1234, 0, 1, 0, 1, 4'd7, 0, 0);
        step();
        chkb("st_we", bus.dmem_we, 1'b1);
        chkw("st_wdata", bus.dmem_wdata, 32'h1234);
        set_ex(32'h55, 32'h0, 0, 0, 0, 1, 4'd9, 0, 0);
        bus.rw_ready = 1'b0;
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chkb("bp_hold", bus.rw_valid, 1'b1);
            chkb("bp_wben", bus.rw_wb_en, 1'b0);
            chkb("bp_noacc", bus.ex_ready, 1'b0);
        end
        bus.rw_ready = 1'b1;
        step();
        idle_in();
        chkw("bp_next", bus.rw_result, 32'h55);
        step();

        // CMP flags persist across a non-CMP op
        set_ex(32'h0, 32'h0, 0, 0, 1, 0, 4'd0, 1, 0);
        step();
        set_ex(32'h1, 32'h0, 0, 0, 0, 1, 4'd1, 0, 1);
        step();
        idle_in();
        chkb("cmp_gt", bus.flag_gt, 1'b1);
        chkb("cmp_eq", bus.flag_eq, 1'b0);
        step();
        chkb("cmp_gt2", bus.flag_gt, 1'b1);
        chkb("cmp_eq2", bus.flag_eq, 1'b0);

        // Reset during a load wait
        set_ex(32'h200, 32'h0, 1, 0, 0, 1, 4'd6, 0, 0);
        step();
        idle_in();
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_outputs("mid");
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h5555_5555;
        step();
        bus.dmem_rvalid = 1'b0;
        chkb("late_rv", bus.rw_valid, 1'b0);
        set_ex(32'h99, 32'h0, 0, 0, 0, 1, 4'd2, 0, 0);
        step();
        idle_in();
        chkw("post_rst", bus.rw_result, 32'h99);
        step();

        // gnt and rvalid in the same cycle
        set_ex(32'h300, 32'h0, 1, 0, 0, 1, 4'd8, 0, 0);
        step();
        idle_in();
        bus.dmem_gnt    = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h0BAD;
        step();
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        step();
        chkb("gr_wait", bus.rw_valid, 1'b0);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h600D;
        step();
        idle_in();
        chkw("gr_res", bus.rw_result, 32'h600D);
        step();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            bus.rw_ready = (($urandom % 4) != 0);
            mem_drive();
            if (!(bus.ex_valid && !last_acc)) begin
                if (($urandom % 4) == 0) begin
                    bus.ex_valid = 1'b0;
                end else begin
                    k = int'($urandom % 9);
                    set_ex($urandom, $urandom,
                           (k == 5 || k == 6 || k == 8),
                           (k == 7 || k == 8), (k == 4),
                           1'($urandom % 2), 4'($urandom % 16),
                           1'($urandom % 2), 1'($urandom % 2));
                end
            end
            step();
        end

        // Drain with a bounded budget
        bus.ex_valid = 1'b0;
        for (int i = 0; i < 40 && m_busy; i++) begin
            bus.rw_ready = 1'b1;
            mem_drive();
            if (m_busy && (m_ld || m_st) && !m_granted) bus.dmem_gnt = 1'b1;
            step();
        end
        chkb("drain_idle", bus.ex_ready, 1'b1);
        chkb("drain_rwv", bus.rw_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
